// File: rtl/s4_timer_pkg.sv
// Shared types for the S4 countdown timer.
// Holds the control FSM state encoding.
package s4_timer_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } timer_state_t;

endpackage

// File: rtl/s4_down_counter.sv
// Loadable down-counter datapath for the S4 countdown timer.
// Ports: clock, reset (sync, active-high), load, load_value, dec_en,
//        q (current value), is_one (q == 1).
module s4_down_counter #(
    parameter int N = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [N-1:0] load_value,
    input  logic         dec_en,
    output logic [N-1:0] q,
    output logic         is_one
);

    localparam logic [N-1:0] ONE = N'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= load_value;
        end else if (dec_en && (q != '0)) begin
            // Saturate at zero so the count can never wrap.
            q <= q - ONE;
        end
    end

    assign is_one = (q == ONE);

endmodule

// File: rtl/s4_countdown_timer.sv
// Loadable countdown timer: counts reload_value..1, then flags expiry.
// Ports: clock, reset (sync, active-high), start, stop, pause,
//        auto_reload, reload_value[N], ack; count[N], busy, done, expired.
module s4_countdown_timer
    import s4_timer_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic         stop,
    input  logic         pause,
    input  logic         auto_reload,
    input  logic [N-1:0] reload_value,
    input  logic         ack,
    output logic [N-1:0] count,
    output logic         busy,
    output logic         done,
    output logic         expired
);

    timer_state_t state, state_n;

    logic         done_q, done_n;
    logic         exp_q, exp_n;
    logic         busy_q, busy_n;
    logic         load;
    logic [N-1:0] load_val;
    logic         dec_en;
    logic         is_one;
    logic         rv_zero;

    assign rv_zero = (reload_value == '0);

    s4_down_counter #(.N(N)) u_cnt (
        .clock      (clock),
        .reset      (reset),
        .load       (load),
        .load_value (load_val),
        .dec_en     (dec_en),
        .q          (count),
        .is_one     (is_one)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            done_q <= 1'b0;
            exp_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state  <= state_n;
            done_q <= done_n;
            exp_q  <= exp_n;
            busy_q <= busy_n;
        end
    end

    always_comb begin
        state_n  = state;
        done_n   = done_q;
        exp_n    = 1'b0;
        load     = 1'b0;
        load_val = '0;
        dec_en   = 1'b0;

        if (stop) begin
            state_n = IDLE;
            done_n  = 1'b0;
            load    = 1'b1;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        // A zero start value expires at once
                        // instead of spinning in RUN.
                        load = 1'b1;
                        if (rv_zero) begin
                            state_n = DONE;
                            done_n  = 1'b1;
                            exp_n   = 1'b1;
                        end else begin
                            state_n  = RUN;
                            done_n   = 1'b0;
                            load_val = reload_value;
                        end
                    end else if (state == DONE && ack) begin
                        state_n = IDLE;
                        done_n  = 1'b0;
                    end
                end
                RUN: begin
                    if (!pause) begin
                        if (is_one) begin
                            exp_n = 1'b1;
                            load  = 1'b1;
                            if (auto_reload && !rv_zero) begin
                                load_val = reload_value;
                            end else begin
                                state_n = DONE;
                                done_n  = 1'b1;
                            end
                        end else begin
                            dec_en = 1'b1;
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                    done_n  = 1'b0;
                    load    = 1'b1;
                end
            endcase
        end

        busy_n = (state_n == RUN);
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign expired = exp_q;

endmodule
